// File: rtl/colpar_pkg.sv
// Shared types and helpers for the column-parity stream unit.
package colpar_pkg;

  typedef enum logic [2:0] {IDLE, ARM, READ, DRAIN, EMIT} state_t;

  localparam int ROWS_DEF = 5;
  localparam int COLS_DEF = 5;
  localparam int NLANES   = ROWS_DEF * COLS_DEF;

  // Upper bound on LANE_W for the width-generic rotate helper.
  localparam int MAX_LANE_W = 512;
  typedef logic [MAX_LANE_W-1:0] wide_t;

  function automatic int nlanes(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Rotate the low w bits of v left by one; bits above w stay zero.
  function automatic wide_t rotl1(input wide_t v, input int w);
    wide_t r;
    r = '0;
    r[0] = v[w-1];
    for (int i = 1; i < MAX_LANE_W; i++)
      if (i < w) r[i] = v[i-1];
    return r;
  endfunction

endpackage

// File: rtl/colpar_ctrl.sv
// Sequencer: start handshake, lane reads, column wrap counter and EMIT indexing.
module colpar_ctrl
  import colpar_pkg::*;
#(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 0,
  parameter int IDX_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              ready,
  output logic              done,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic              acc_en,
  output logic [IDX_W-1:0]  acc_col,
  output logic              clr
);

  localparam int NL  = nlanes(ROWS, COLS);
  localparam int K_W = idx_w(NL);

  state_t           state;
  logic [K_W-1:0]   k;
  logic [IDX_W-1:0] col;

  assign clr = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_rd    <= 1'b0;
      mem_addr  <= ADDR_W'(BASE_ADDR);
      k         <= '0;
      col       <= '0;
      acc_en    <= 1'b0;
      acc_col   <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      done    <= 1'b0;
      // Read data lands one cycle later, so the column tag follows it by one.
      acc_en  <= mem_rd;
      acc_col <= col;
      case (state)
        IDLE: if (start) begin
          state <= ARM;
          ready <= 1'b0;
        end
        ARM: if (!start) begin
          state    <= READ;
          mem_rd   <= 1'b1;
          mem_addr <= ADDR_W'(BASE_ADDR);
          k        <= '0;
          col      <= '0;
        end
        READ: begin
          if (k == K_W'(NL - 1)) begin
            state  <= DRAIN;
            mem_rd <= 1'b0;
          end else begin
            k        <= k + 1'b1;
            mem_addr <= mem_addr + 1'b1;
            col      <= (col == IDX_W'(COLS - 1)) ? '0 : col + 1'b1;
          end
        end
        DRAIN: begin
          state     <= EMIT;
          out_valid <= 1'b1;
          out_idx   <= '0;
        end
        EMIT: if (out_ready) begin
          if (out_idx == IDX_W'(COLS - 1)) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
            done      <= 1'b1;
            ready     <= 1'b1;
          end else begin
            out_idx <= out_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/colpar_stream_unit.sv
// Column-parity engine: accumulates C[x] over ROWS lanes and streams COLS words.
// Define COLPAR_THETA_D_EN to emit D[x] = C[x-1] ^ rotl1(C[x+1]) instead of C[x].
module colpar_stream_unit
  import colpar_pkg::*;
#(
  parameter int LANE_W    = 64,
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [LANE_W-1:0]        mem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(COLS)-1:0]  out_idx,
  output logic [LANE_W-1:0]        out_data,
  output logic                     ready,
  output logic                     done
);

  localparam int IDX_W = $clog2(COLS);

  logic              acc_en, clr;
  logic [IDX_W-1:0]  acc_col;
  logic [LANE_W-1:0] c [COLS];
  logic [LANE_W-1:0] word;

  colpar_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
  ) u_ctrl (
    .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .ready(ready), .done(done),
    .out_valid(out_valid), .out_idx(out_idx),
    .acc_en(acc_en), .acc_col(acc_col), .clr(clr)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < COLS; i++) c[i] <= '0;
    end else if (acc_en) begin
      c[acc_col] <= c[acc_col] ^ mem_rdata;
    end
  end

`ifdef COLPAR_THETA_D_EN
  logic [IDX_W-1:0] xm, xp;
  wide_t            rot;
  always_comb begin
    xm   = (out_idx == '0) ? IDX_W'(COLS - 1) : out_idx - 1'b1;
    xp   = (out_idx == IDX_W'(COLS - 1)) ? '0 : out_idx + 1'b1;
    rot  = rotl1(wide_t'(c[xp]), LANE_W);
    word = c[xm] ^ rot[LANE_W-1:0];
  end
`else
  always_comb begin
    word = c[out_idx];
  end
`endif

  // Parity is only meaningful while a word is offered.
  assign out_data = out_valid ? word : '0;

endmodule
